// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, priced vend, change return and cancel refund.
// Optional macro VEND_TIMEOUT_EN refunds credit after TIMEOUT_CYCLES cycles without input events.
module vend_controller #(
    parameter int unsigned NUM_PRODUCTS    = 9,
    parameter int unsigned BASE_PRICE      = 50,
    parameter int unsigned PRICE_STEP      = 25,
    parameter int unsigned MAX_CREDIT      = 995,
    parameter int unsigned DISPENSE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 20000
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic [2:0] coin,
    input  logic [3:0] productSelect,
    input  logic       cancel,
    output logic       dispense,
    output logic [9:0] money,
    output logic [9:0] change,
    output logic       change_valid,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       busy
);

    if (NUM_PRODUCTS == 0 || NUM_PRODUCTS > 15 || MAX_CREDIT > 1023 || DISPENSE_CYCLES == 0 ||
        TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("vend_controller: parameter out of range");
    end

    localparam int unsigned DcntW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StCredit, StDispense, StChange} state_e;

    state_e             state_q, state_d;
    logic [9:0]         credit_q, credit_d;
    logic [9:0]         change_q, change_d;
    logic [DcntW-1:0]   dcnt_q, dcnt_d;
    logic               dispense_q, dispense_d;
    logic               change_valid_q, change_valid_d;
    logic               coin_reject_q, coin_reject_d;
    logic               insufficient_q, insufficient_d;
    logic               busy_q, busy_d;
    logic [2:0]         coin_prev_q;
    logic [3:0]         sel_prev_q;
    logic               cancel_prev_q;

    logic               coin_ev, sel_ev, cancel_ev, any_ev, timeout;
    logic               coin_ok, sel_ok, vend;
    logic [9:0]         coin_val;
    logic [10:0]        price, sum;

    assign coin_ev   = (coin != 3'd0) && (coin_prev_q == 3'd0);
    assign sel_ev    = (productSelect != 4'd0) && (sel_prev_q == 4'd0);
    assign cancel_ev = cancel && !cancel_prev_q;
    assign any_ev    = coin_ev || sel_ev || cancel_ev;
    assign sel_ok    = (32'(productSelect) <= NUM_PRODUCTS);

    always_comb begin
        coin_val = '0;
        coin_ok  = 1'b1;
        case (coin)
            3'd1:    coin_val = 10'd5;
            3'd2:    coin_val = 10'd10;
            3'd3:    coin_val = 10'd25;
            3'd4:    coin_val = 10'd100;
            default: coin_ok = 1'b0;
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TmoW-1:0] tmo_q, tmo_d;

    // Counts eventless cycles spent in CREDIT; any event or other state restarts it.
    always_comb begin
        tmo_d   = '0;
        timeout = 1'b0;
        if (state_q == StCredit && !any_ev) begin
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
            else                                    tmo_d   = tmo_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        dcnt_d         = dcnt_q;
        dispense_d     = 1'b0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;
        busy_d         = 1'b0;
        vend           = 1'b0;
        price          = 11'(BASE_PRICE) + 11'(PRICE_STEP) * (11'(productSelect) - 11'd1);
        sum            = {1'b0, credit_q} + {1'b0, coin_val};

        case (state_q)
            StIdle, StCredit: begin
                if ((cancel_ev && state_q == StCredit) || timeout) begin
                    change_d       = credit_q;
                    credit_d       = '0;
                    state_d        = StChange;
                    change_valid_d = 1'b1;
                    busy_d         = 1'b1;
                    coin_reject_d  = coin_ev;
                end else begin
                    // Select sees the pre-coin credit; a same-cycle coin is only kept if no vend.
                    if (sel_ev && sel_ok) begin
                        if ({1'b0, credit_q} >= price) begin
                            vend       = 1'b1;
                            change_d   = credit_q - price[9:0];
                            credit_d   = '0;
                            state_d    = StDispense;
                            dcnt_d     = '0;
                            dispense_d = 1'b1;
                            busy_d     = 1'b1;
                        end else begin
                            insufficient_d = 1'b1;
                        end
                    end
                    if (coin_ev) begin
                        if (vend || !coin_ok || sum > 11'(MAX_CREDIT)) begin
                            coin_reject_d = 1'b1;
                        end else begin
                            credit_d = sum[9:0];
                            state_d  = StCredit;
                        end
                    end
                end
            end
            StDispense: begin
                busy_d        = 1'b1;
                coin_reject_d = coin_ev;
                if (dcnt_q == DcntW'(DISPENSE_CYCLES - 1)) begin
                    state_d        = StChange;
                    change_valid_d = 1'b1;
                end else begin
                    dcnt_d     = dcnt_q + DcntW'(1);
                    dispense_d = 1'b1;
                end
            end
            StChange: begin
                coin_reject_d = coin_ev;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            credit_q       <= '0;
            change_q       <= '0;
            dcnt_q         <= '0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            busy_q         <= 1'b0;
            coin_prev_q    <= '0;
            sel_prev_q     <= '0;
            cancel_prev_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            dcnt_q         <= dcnt_d;
            dispense_q     <= dispense_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
            busy_q         <= busy_d;
            coin_prev_q    <= coin;
            sel_prev_q     <= productSelect;
            cancel_prev_q  <= cancel;
        end
    end

    assign dispense     = dispense_q;
    assign money        = credit_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;
    assign insufficient = insufficient_q;
    assign busy         = busy_q;

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the vending machine: accumulates coin credit, resolves product selections against a parameterised price table, sequences the dispense pulse and change return, and refunds on cancel or inactivity. It sits between the debounced front-panel inputs (`coin`, `productSelect`) and the BCD/seven-segment display path, which consumes its binary `money` and `change` outputs.

## Interface
- `NUM_PRODUCTS`, 9: valid selections are 1..NUM_PRODUCTS (max 15).
- `BASE_PRICE`, 50: price of product 1, in cents.
- `PRICE_STEP`, 25: price increment per product index, in cents.
- `MAX_CREDIT`, 995: credit ceiling in cents; must be ≤ 1023.
- `DISPENSE_CYCLES`, 4: width of the `dispense` pulse.
- `TIMEOUT_CYCLES`, 20000: inactivity limit; only used with VEND_TIMEOUT_EN.
- `clk50` in 1: system clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `coin` in 3: coin code. 0 none, 1 = 5¢, 2 = 10¢, 3 = 25¢, 4 = 100¢, 5–7 invalid.
- `productSelect` in 4: 0 none, otherwise product index.
- `cancel` in 1: refund request, level.
- `dispense` out 1: product release pulse.
- `money` out 10: current credit, binary cents.
- `change` out 10: change of last transaction, binary cents, held.
- `change_valid` out 1: one-cycle strobe when `change` is updated.
- `coin_reject` out 1: one-cycle strobe, coin returned.
- `insufficient` out 1: one-cycle strobe, selection refused.
- `busy` out 1: high in DISPENSE and CHANGE.

## Operation
- Input events are edge-detected internally: a coin event is `coin != 0` while the registered previous `coin == 0`. Select and cancel events are defined the same way. Held inputs generate exactly one event.
- States: IDLE (credit 0), CREDIT, DISPENSE, CHANGE.
- Coin event in IDLE/CREDIT:
  - Code 5–7, or credit + value > MAX_CREDIT: `coin_reject` strobes and credit is unchanged.
  - Otherwise the value is added to credit and the state goes to CREDIT.
- Select event in IDLE/CREDIT:
  - Index > NUM_PRODUCTS: ignored.
  - Otherwise price = BASE_PRICE + PRICE_STEP×(index−1).
  - If credit ≥ price: `change` ← credit − price, credit ← 0, go to DISPENSE.
  - Else: `insufficient` strobes and the state is unchanged.
- Coin and select events in the same cycle: select is evaluated against the pre-coin credit.
  - If the select vends, the coin is rejected.
  - Otherwise the coin is credited normally.
- Cancel event in CREDIT: `change` ← credit, credit ← 0, go to CHANGE; no dispense. Cancel has priority over select and coin in the same cycle, and the coin is rejected.
- DISPENSE: `dispense` is high for DISPENSE_CYCLES cycles, then the state goes to CHANGE.
- CHANGE: `change_valid` is high for exactly 1 cycle, then the state goes to IDLE.
- In DISPENSE/CHANGE, coin events strobe `coin_reject`; select and cancel events are dropped.
- Arithmetic is 10-bit unsigned with an 11-bit intermediate for the ceiling compare; credit never wraps.

## Timing
- Reset values: `dispense`=0, `money`=0, `change`=0, `change_valid`=0, `coin_reject`=0, `insufficient`=0, `busy`=0, state IDLE, edge-detect registers 0.
- Coin latency: an event sampled at edge N shows on `money` after edge N; `coin_reject` and `insufficient` are high for the cycle following edge N.
- Vend: the select is sampled at edge N. `money`=0 and `dispense`=1 for cycles N+1..N+DISPENSE_CYCLES. `change_valid`=1 in cycle N+DISPENSE_CYCLES+1, and `busy` is high over the same span.
- Cancel: `change_valid` is high in cycle N+1. `busy` is high that cycle only.
- Asynchronous reset mid-DISPENSE: all outputs clear immediately and credit is lost. The bench checks this; it is not a fault.

## Configuration
- `VEND_TIMEOUT_EN` defined: an inactivity counter runs in CREDIT and clears on any coin, select or cancel event. On reaching TIMEOUT_CYCLES it behaves exactly like a cancel event.
- `VEND_TIMEOUT_EN` undefined: there is no counter and credit is held indefinitely.

## Test plan
- Reset, then 25¢, 25¢, 10¢ events → `money`=25, 50, 60. Select 1 → `dispense` high 4 cycles, `change_valid` with `change`=10, `money`=0.
- Credit 30¢, select 2 (price 75) → `insufficient` 1 cycle, `money` stays 30. Select 10 → no response.
- Credit 900¢, then 100¢ → `coin_reject`, `money`=900. Coin code 6 → `coin_reject`.
- Credit 100¢, cancel and 5¢ in the same cycle → `change`=100, `change_valid`, `coin_reject`, no `dispense`.
- Credit 100¢, select 1 held 10 cycles plus a 10¢ coin during DISPENSE → exactly one vend, `change`=50, `coin_reject` once, `busy` high 5 cycles.
- With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=8: 5¢ then idle → refund `change`=5 after 8 cycles. Without the macro → `money` stays 5. Separately, drive `reset` low during DISPENSE → all outputs 0 immediately.
